// File: rtl/morse_tx.sv
// Pops ASCII characters from a FIFO and keys them out as International Morse.
// Timing is counted in units of UNIT_CLKS clocks; key_o is registered.
module morse_tx #(
  parameter int WORD_BITS = 8,
  parameter int UNIT_CLKS = 10000000
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 fifo_empty_i,
  input  logic [WORD_BITS-1:0] fifo_rdata_i,
  output logic                 fifo_read_o,
  output logic                 key_o,
  output logic                 busy_o,
  output logic                 bad_char_o
);

  localparam int CW = $clog2(7*UNIT_CLKS);
  localparam logic [CW-1:0] LAST1 = CW'(UNIT_CLKS-1);
  localparam logic [CW-1:0] LAST3 = CW'(3*UNIT_CLKS-1);
  localparam logic [CW-1:0] LAST7 = CW'(7*UNIT_CLKS-1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, MARK, GAP_EL, GAP_CHAR, GAP_WORD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [6:0]    ch;
  logic [4:0]    pat;      // remaining elements, current one at bit 4
  logic [2:0]    rem;      // elements left including the current one
  logic [6:0]    up;
  logic [7:0]    code;
  logic          is_space;
  logic          rd_nxt;
  logic          unused_hi;

  assign unused_hi = ^fifo_rdata_i[WORD_BITS-1:7];

  // {element count, pattern left-aligned}; count 0 marks an unsupported code
  function automatic logic [7:0] enc(input logic [6:0] c);
    case (c)
      7'h41: enc = {3'd2, 5'b01000};  7'h42: enc = {3'd4, 5'b10000};
      7'h43: enc = {3'd4, 5'b10100};  7'h44: enc = {3'd3, 5'b10000};
      7'h45: enc = {3'd1, 5'b00000};  7'h46: enc = {3'd4, 5'b00100};
      7'h47: enc = {3'd3, 5'b11000};  7'h48: enc = {3'd4, 5'b00000};
      7'h49: enc = {3'd2, 5'b00000};  7'h4A: enc = {3'd4, 5'b01110};
      7'h4B: enc = {3'd3, 5'b10100};  7'h4C: enc = {3'd4, 5'b01000};
      7'h4D: enc = {3'd2, 5'b11000};  7'h4E: enc = {3'd2, 5'b10000};
      7'h4F: enc = {3'd3, 5'b11100};  7'h50: enc = {3'd4, 5'b01100};
      7'h51: enc = {3'd4, 5'b11010};  7'h52: enc = {3'd3, 5'b01000};
      7'h53: enc = {3'd3, 5'b00000};  7'h54: enc = {3'd1, 5'b10000};
      7'h55: enc = {3'd3, 5'b00100};  7'h56: enc = {3'd4, 5'b00010};
      7'h57: enc = {3'd3, 5'b01100};  7'h58: enc = {3'd4, 5'b10010};
      7'h59: enc = {3'd4, 5'b10110};  7'h5A: enc = {3'd4, 5'b11000};
      7'h30: enc = {3'd5, 5'b11111};  7'h31: enc = {3'd5, 5'b01111};
      7'h32: enc = {3'd5, 5'b00111};  7'h33: enc = {3'd5, 5'b00011};
      7'h34: enc = {3'd5, 5'b00001};  7'h35: enc = {3'd5, 5'b00000};
      7'h36: enc = {3'd5, 5'b10000};  7'h37: enc = {3'd5, 5'b11000};
      7'h38: enc = {3'd5, 5'b11100};  7'h39: enc = {3'd5, 5'b11110};
      default: enc = 8'h00;
    endcase
  endfunction

  assign up       = (ch >= 7'h61 && ch <= 7'h7A) ? ch - 7'h20 : ch;
  assign code     = enc(up);
  assign is_space = (ch == 7'h20);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (fifo_read_o) state_nxt = FETCH;
      FETCH:    state_nxt = LOAD;
      LOAD:     if (is_space)              state_nxt = GAP_WORD;
                else if (code[7:5] != 3'd0) state_nxt = MARK;
                else                       state_nxt = IDLE;
      MARK:     if (cnt == (pat[4] ? LAST3 : LAST1))
                  state_nxt = (rem > 3'd1) ? GAP_EL : GAP_CHAR;
      GAP_EL:   if (cnt == LAST1) state_nxt = MARK;
      GAP_CHAR: if (cnt == LAST3) state_nxt = IDLE;
      GAP_WORD: if (cnt == LAST7) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    // pop is decided on the way into IDLE so it lands in IDLE's first cycle
    rd_nxt = (state_nxt == IDLE) && !fifo_empty_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      cnt         <= '0;
      fifo_read_o <= 1'b0;
      key_o       <= 1'b0;
      ch          <= '0;
      pat         <= '0;
      rem         <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= (state_nxt != state) ? '0 : cnt + 1'b1;
      fifo_read_o <= rd_nxt;
      key_o       <= (state_nxt == MARK);
      if (state == FETCH) ch <= fifo_rdata_i[6:0];
      if (state == LOAD) begin
        pat <= code[4:0];
        rem <= code[7:5];
      end
      if (state == MARK && state_nxt == GAP_EL) begin
        pat <= {pat[3:0], 1'b0};
        rem <= rem - 3'd1;
      end
    end
  end

  assign busy_o     = (state != IDLE);
  assign bad_char_o = (state == LOAD) && !is_space && (code[7:5] == 3'd0);

endmodule

// File: tb/tb_morse_tx.sv
// Bench for morse_tx: a FIFO model plus a Morse-string timeline model checked every cycle,
// with literal run-length expectations per test.
module tb_morse_tx;
  localparam int U = 4;

  logic       clk = 1'b0;
  logic       reset_i, fifo_empty_i, fifo_read_o, key_o, busy_o, bad_char_o;
  logic [7:0] fifo_rdata_i;

  always #5 clk = ~clk;

  morse_tx #(.WORD_BITS(8), .UNIT_CLKS(U)) dut (
    .clk_i(clk), .reset_i(reset_i), .fifo_empty_i(fifo_empty_i), .fifo_rdata_i(fifo_rdata_i),
    .fifo_read_o(fifo_read_o), .key_o(key_o), .busy_o(busy_o), .bad_char_o(bad_char_o)
  );

  typedef struct packed { logic key; logic busy; logic bad; } exp_t;

  exp_t exp_q[$];
  byte  fq[$];
  bit   hist[$];
  int   hi_q[$], lo_q[$];
  int   nerr = 0, nchk = 0;
  int   pops, bads, rises, starve, cyc, t_pop, t_rise;
  bit   rd_seen, prev_key;

  function automatic exp_t mk(input logic k, input logic b, input logic x);
    exp_t e;
    e.key = k; e.busy = b; e.bad = x;
    return e;
  endfunction

  // "" = unsupported, " " = word space
  function automatic string morse(input byte c0);
    byte c;
    c = c0 & 8'h7f;
    if (c >= 8'h61 && c <= 8'h7a) c = c - 8'h20;
    case (c)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
      " ": return " ";
      default: return "";
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // expected outputs from the cycle after the pop until the block is idle again
  task automatic expand(input byte c);
    string m;
    m = morse(c);
    exp_q.push_back(mk(0, 1, 0));
    if (m.len() == 0) begin
      exp_q.push_back(mk(0, 1, 1));
      return;
    end
    exp_q.push_back(mk(0, 1, 0));
    if (m == " ") begin
      repeat (7*U) exp_q.push_back(mk(0, 1, 0));
      return;
    end
    for (int i = 0; i < m.len(); i++) begin
      repeat ((m[i] == 8'h2d) ? 3*U : U) exp_q.push_back(mk(1, 1, 0));
      repeat ((i == m.len()-1) ? 3*U : U) exp_q.push_back(mk(0, 1, 0));
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk); #1;
    if (rd_seen) begin
      if (fq.size() != 0) fifo_rdata_i = fq.pop_front();
      rd_seen = 0;
    end
    fifo_empty_i = (fq.size() == 0);
    @(negedge clk);
    cyc++;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : mk(0, 0, 0);
    chk("key", {31'd0, key_o}, {31'd0, e.key});
    chk("busy", {31'd0, busy_o}, {31'd0, e.busy});
    chk("bad", {31'd0, bad_char_o}, {31'd0, e.bad});
    hist.push_back(key_o);
    if (key_o && !prev_key) begin
      rises++;
      if (t_rise < 0) t_rise = cyc;
    end
    prev_key = key_o;
    if (bad_char_o) bads++;
    if (fifo_read_o) begin
      pops++;
      starve = 0;
      if (t_pop < 0) t_pop = cyc;
      chk("pop_when_idle", exp_q.size(), 0);
      if (fq.size() == 0) chk("pop_nonempty", 0, 1);
      else begin
        expand(fq[0]);
        rd_seen = 1;
      end
    end else if (exp_q.size() == 0 && fq.size() != 0 && !reset_i) begin
      starve++;
      if (starve == 3) chk("pop_timely", starve, 0);
    end
  endtask

  task automatic push(input byte c);
    fq.push_back(c);
    fifo_empty_i = 1'b0;
  endtask

  task automatic clear_meas();
    hist.delete();
    pops = 0; bads = 0; rises = 0; starve = 0;
    t_pop = -1; t_rise = -1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || rd_seen) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("idle_timeout", n, 0);
    repeat (3) tick();
  endtask

  // high-run lengths and the low runs strictly between highs
  task automatic analyze();
    int rv[$], rl[$];
    hi_q.delete(); lo_q.delete();
    foreach (hist[i]) begin
      if (rv.size() != 0 && rv[rv.size()-1] == int'(hist[i])) rl[rl.size()-1]++;
      else begin
        rv.push_back(int'(hist[i]));
        rl.push_back(1);
      end
    end
    for (int i = 0; i < rv.size(); i++) begin
      if (rv[i] == 1) hi_q.push_back(rl[i]);
      else if (i > 0 && i < rv.size()-1) lo_q.push_back(rl[i]);
    end
  endtask

  initial begin
    int n;
    reset_i = 1'b1; fifo_empty_i = 1'b1; fifo_rdata_i = 8'h00;
    rd_seen = 0; prev_key = 0; cyc = 0;
    clear_meas();
    tick(); tick();
    reset_i = 1'b0;
    chk("rst_key", {31'd0, key_o}, 0);
    chk("rst_read", {31'd0, fifo_read_o}, 0);
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_bad", {31'd0, bad_char_o}, 0);
    repeat (50) tick();
    chk("empty_no_pop", pops, 0);

    clear_meas();
    push("E");
    wait_idle(300);
    analyze();
    chk("E_pops", pops, 1);
    chk("E_latency", t_rise - t_pop, 3);
    chk("E_nmarks", hi_q.size(), 1);
    if (hi_q.size() == 1) chk("E_mark", hi_q[0], 4);

    clear_meas();
    push(8'h61);
    wait_idle(300);
    analyze();
    chk("a_pops", pops, 1);
    chk("a_nmarks", hi_q.size(), 2);
    if (hi_q.size() == 2) begin
      chk("a_dot", hi_q[0], 4);
      chk("a_dash", hi_q[1], 12);
    end
    if (lo_q.size() == 1) chk("a_elgap", lo_q[0], 4);
    else chk("a_nelgap", lo_q.size(), 1);

    clear_meas();
    push("E"); push("T");
    wait_idle(400);
    analyze();
    chk("ET_pops", pops, 2);
    chk("ET_nmarks", hi_q.size(), 2);
    if (hi_q.size() == 2) begin
      chk("ET_E", hi_q[0], 4);
      chk("ET_T", hi_q[1], 12);
    end
    if (lo_q.size() == 1) chk("ET_chargap", lo_q[0], 3*U + 3);
    else chk("ET_nchargap", lo_q.size(), 1);

    clear_meas();
    push(8'h23); push("5");
    wait_idle(400);
    analyze();
    chk("b5_pops", pops, 2);
    chk("b5_bad_pulses", bads, 1);
    chk("b5_nmarks", hi_q.size(), 5);
    chk("b5_ngaps", lo_q.size(), 4);
    foreach (hi_q[i]) chk("b5_dot", hi_q[i], 4);
    foreach (lo_q[i]) chk("b5_gap", lo_q[i], 4);

    clear_meas();
    push("O");
    n = 0;
    while (rises < 2 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("O_second_dash_timeout", n, 0);
    repeat (3) tick();
    chk("O_in_dash", {31'd0, key_o}, 1);
    reset_i = 1'b1;
    exp_q.delete();
    tick();
    chk("O_rst_key", {31'd0, key_o}, 0);
    chk("O_rst_busy", {31'd0, busy_o}, 0);
    tick();
    reset_i = 1'b0;
    repeat (20) tick();
    chk("O_pops", pops, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
